// File: rtl/sk9822_frame_sched_if.sv
// Word stream between the frame scheduler and the SK9822 bit serializer.
//   word_valid : word_data/word_last are valid (master -> slave)
//   word_data  : 32-bit chain word, MSB sent first
//   word_last  : marks the final end word of a frame
//   word_ready : slave accepts the word; transfer = word_valid & word_ready
interface sk9822_frame_sched_if;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;

    modport master (
        output word_valid,
        output word_data,
        output word_last,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        input  word_last,
        output word_ready
    );
endinterface

// File: rtl/sk9822_frame_sched.sv
// Frame scheduler for an SK9822 LED chain.
// Keeps a double-buffered store of LED_NUM 24-bit colours and emits one full chain
// frame (start word, one word per pixel, END_WORDS end words) as 32-bit words on a
// valid/ready stream. A frame is sent on host commit (which also publishes the back
// bank and latches brightness) and on every refresh tick.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : pixel write into the current back bank
//   bright          : global 5-bit brightness, latched when the banks swap
//   commit          : 1-cycle pulse, publish back bank and send a frame
//   busy            : a frame is in progress
//   frame_done      : pulse on the cycle the final end word transfers
//   word            : word stream towards the serializer (master side)
module sk9822_frame_sched #(
    parameter int unsigned LED_NUM     = 12,
    parameter int unsigned AW          = 4,
    parameter int unsigned END_WORDS   = 1,
    parameter int unsigned CLK_FRE     = 27_000_000,
    parameter int unsigned REFRESH_HZ  = 100,
    parameter int unsigned REFRESH_DIV = CLK_FRE / REFRESH_HZ
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [23:0]          wr_data,
    input  logic [4:0]           bright,
    input  logic                 commit,
    output logic                 busy,
    output logic                 frame_done,
    sk9822_frame_sched_if.master word
);
    localparam int unsigned IW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam int unsigned CW = $clog2(LED_NUM + END_WORDS + 1);
    localparam int unsigned TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StPixel, StEnd} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;          // pixel index in StPixel, end-word index in StEnd
    logic            front_q;
    logic [4:0]      bright_q;
    logic            commit_pend_q, commit_pend_d;
    logic            refresh_pend_q, refresh_pend_d;
    logic [TW-1:0]   timer_q;
    logic [23:0]     bank_q [2][LED_NUM];

    logic            tick;
    logic            start_req;
    logic            frame_start;
    logic            swap;
    logic            wr_ok;
    logic            back_sel;
    logic            last_end;
    logic            valid;
    logic            xfer;
    logic [31:0]     data;

    assign tick      = (timer_q == TW'(REFRESH_DIV - 1));
    assign start_req = commit | tick | commit_pend_q | refresh_pend_q;
    assign swap      = frame_start & (commit | commit_pend_q);
    assign back_sel  = ~front_q;
    assign wr_ok     = wr_en && (32'(wr_addr) < LED_NUM);
    assign last_end  = (state_q == StEnd) && (cnt_q == CW'(END_WORDS - 1));
    assign xfer      = valid & word.word_ready;

    assign busy            = (state_q != StIdle);
    assign frame_done      = last_end & xfer;
    assign word.word_valid = valid;
    assign word.word_data  = data;
    assign word.word_last  = last_end;

    // Requests arriving mid-frame collapse into one pending frame.
    assign commit_pend_d  = frame_start ? 1'b0 : (commit_pend_q | commit);
    assign refresh_pend_d = frame_start ? 1'b0 : (refresh_pend_q | tick);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid       = 1'b0;
        data        = 32'h0000_0000;
        frame_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    frame_start = 1'b1;
                    state_d     = StStart;
                end
            end
            StStart: begin
                valid = 1'b1;
                if (word.word_ready) begin
                    state_d = StPixel;
                    cnt_d   = '0;
                end
            end
            StPixel: begin
                valid = 1'b1;
                data  = {3'b111, bright_q, bank_q[front_q][cnt_q[IW-1:0]]};
                if (word.word_ready) begin
                    if (cnt_q == CW'(LED_NUM - 1)) begin
                        state_d = StEnd;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StEnd: begin
                valid = 1'b1;
                data  = 32'hFFFF_FFFF;
                if (word.word_ready) begin
                    if (last_end) begin
                        // Chain straight into the next frame when one is requested.
                        if (start_req) begin
                            frame_start = 1'b1;
                            state_d     = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            front_q        <= 1'b0;
            bright_q       <= '0;
            commit_pend_q  <= 1'b0;
            refresh_pend_q <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            commit_pend_q  <= commit_pend_d;
            refresh_pend_q <= refresh_pend_d;
            timer_q        <= tick ? '0 : timer_q + TW'(1);
            if (swap) begin
                front_q  <= ~front_q;
                bright_q <= bright;
            end
        end
    end

    // A write on the swap cycle targets the old back bank, which becomes front on the
    // same edge, so it shows up in the frame being started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(LED_NUM); i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (wr_ok) begin
            bank_q[back_sel][wr_addr[IW-1:0]] <= wr_data;
        end
    end
endmodule
